error_rate_thresh_mon: RTL and testbench
========================================

// Module: error_rate_thresh_mon
// PURPOSE
//  Next-generation per-source error monitor for the RCD error-management path. Counts error events
//  per source in a leaky window: counts halve at each window boundary. Runs a 4-state escalation FSM
//  per source with hysteresis and sticky fatal. Drives masked W1C interrupts and system-level flags.
// PARAMETERS
//  NUM_SRC  8   number of error sources (1..32)
//  CNT_W    16  per-source event counter width (saturating)
//  WIN_W    20  window-length register width (window in clk cycles)
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            asynchronous active-low reset
//  enable       in   1            0: all state, counters and timer hold; events ignored
//  err_valid    in   NUM_SRC      per-source error event this cycle
//  err_sev      in   2*NUM_SRC    per-source severity {sev[2i+1:2i]}: 0 info, 1 warn, 2 err, 3 fatal
//  cfg_load     in   1            pulse: capture cfg_* below
//  cfg_warn_thr in   CNT_W        warn threshold
//  cfg_fail_thr in   CNT_W        fail threshold
//  cfg_hyst     in   CNT_W        de-escalation hysteresis
//  cfg_window   in   WIN_W        window length; 0 = decay disabled
//  clr_src      in   NUM_SRC      pulse: clear count and FSM of source i (incl. FATAL)
//  int_mask     in   NUM_SRC      1 = interrupt enabled for source i
//  int_clr      in   NUM_SRC      W1C pulse for int_status
//  src_state    out  2*NUM_SRC    per-source FSM: 0 OK, 1 WARN, 2 FAIL, 3 FATAL
//  src_count    out  CNT_W*NUM_SRC per-source current count
//  int_status   out  NUM_SRC      sticky escalation flags
//  irq          out  1            |(int_status & int_mask), combinational from regs
//  sys_warn/sys_fail/sys_fatal out 1 any source in >=WARN / >=FAIL / FATAL (combinational from regs)
//  win_tick     out  1            registered; high 1 cycle at each window boundary
// BEHAVIOUR
//  Reset: counts 0; states OK; int_status 0; win timer 0; win_tick 0.
//   Config regs at reset: warn_thr 8, fail_thr 16, hyst 2, window 0.
//  Window timer (enable=1, window!=0): counts 0..window-1. Boundary at window-1: win_tick=1 next cycle,
//   timer wraps to 0. cfg_load restarts timer at 0. Config takes effect the cycle after cfg_load.
//  Count update per edge, priority high->low:
//   clr_src[i] -> 0;
//   boundary   -> (cnt>>1) + err_valid[i];
//   else       -> cnt + err_valid[i].
//   Saturate at 2^CNT_W-1 (never wraps).
//  FSM evaluates the registered count, so a state change lands 1 cycle after the count edge:
//   OK->WARN     cnt>=warn_thr
//   any<FAIL->FAIL  cnt>=fail_thr (fail check dominates; may skip WARN)
//   FAIL->WARN   cnt < fail_thr-hyst
//   WARN->OK     cnt < warn_thr-hyst (subtractions saturate at 0)
//   FAIL->FATAL  err_valid[i] with sev==3 while in FAIL; FATAL is sticky, left only via clr_src or reset.
//   clr_src forces OK the same edge. One transition per cycle, recomputed each cycle.
//  int_status[i] set on any escalation (OK->WARN, ->FAIL, ->FATAL), regardless of mask.
//   Simultaneous set and int_clr: set wins. De-escalation never sets it.
//  enable=0 mid-operation: everything frozen, outputs hold. cfg_load ignored. clr_src/int_clr ignored.
//  Reset mid-window: all state returns to reset values immediately (async).
// TESTING
//  T1: cfg warn=4 fail=8 hyst=2 win=0; 4 events on src0 -> count 4, state WARN 1 cycle later.
//   int_status[0]=1; irq=1 only if int_mask[0].
//  T2: continue to 8 events -> FAIL, sys_fail=1. Then one sev=3 event -> FATAL, sys_fatal=1.
//   clr_src[0] -> count 0, state OK.
//  T3: win=16, cnt 8 in FAIL, no events -> at tick cnt 4: 4<8-2 -> WARN.
//   Next tick cnt 2: 2 not < 4-2 -> stays WARN. Next tick cnt 1 -> OK. win_tick every 16 cycles.
//  T4: CNT_W=4, 20 events back-to-back -> count saturates at 15, no wrap.
//   Event on same cycle as boundary at cnt 15 -> 8.
//  T5: escalation same cycle as int_clr[i] -> int_status stays 1.
//   clr_src and err_valid same cycle -> count 0.
//  T6: enable=0 for 50 cycles with events and win=10 -> counts, states, timer unchanged.
//   Async rst_n mid-window -> all outputs at reset values.

Source files
------------

// File: rtl/error_rate_thresh_mon.sv
// rtl/error_rate_thresh_mon.sv - per-source leaky-window error counter with escalation FSM and W1C interrupts
module error_rate_thresh_mon #(
    parameter int NUM_SRC = 8,
    parameter int CNT_W   = 16,
    parameter int WIN_W   = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_SRC-1:0]       err_valid,
    input  logic [2*NUM_SRC-1:0]     err_sev,
    input  logic                     cfg_load,
    input  logic [CNT_W-1:0]         cfg_warn_thr,
    input  logic [CNT_W-1:0]         cfg_fail_thr,
    input  logic [CNT_W-1:0]         cfg_hyst,
    input  logic [WIN_W-1:0]         cfg_window,
    input  logic [NUM_SRC-1:0]       clr_src,
    input  logic [NUM_SRC-1:0]       int_mask,
    input  logic [NUM_SRC-1:0]       int_clr,
    output logic [2*NUM_SRC-1:0]     src_state,
    output logic [CNT_W*NUM_SRC-1:0] src_count,
    output logic [NUM_SRC-1:0]       int_status,
    output logic                     irq,
    output logic                     sys_warn,
    output logic                     sys_fail,
    output logic                     sys_fatal,
    output logic                     win_tick
);

    typedef enum logic [1:0] {ST_OK, ST_WARN, ST_FAIL, ST_FATAL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   warn_thr_q, fail_thr_q, hyst_q;
    logic [CNT_W-1:0]   warn_lo, fail_lo;
    logic [WIN_W-1:0]   window_q, timer_q, timer_d;
    logic               win_tick_q, win_tick_d, boundary;
    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d [NUM_SRC];
    logic [CNT_W-1:0]   base  [NUM_SRC];
    logic [CNT_W:0]     sum   [NUM_SRC];
    state_t             state_q [NUM_SRC];
    state_t             state_d [NUM_SRC];
    logic [NUM_SRC-1:0] int_status_q, int_status_d, esc;

    always_comb begin
        boundary   = enable && (window_q != '0) && (timer_q == window_q - WIN_W'(1));
        timer_d    = timer_q;
        win_tick_d = win_tick_q;
        if (enable) begin
            win_tick_d = boundary;
            if (cfg_load || boundary || (window_q == '0)) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + WIN_W'(1);
            end
        end
        // De-escalation thresholds floor at zero rather than wrapping
        warn_lo = (warn_thr_q > hyst_q) ? warn_thr_q - hyst_q : '0;
        fail_lo = (fail_thr_q > hyst_q) ? fail_thr_q - hyst_q : '0;
    end

    always_comb begin
        esc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            base[i]    = boundary ? (cnt_q[i] >> 1) : cnt_q[i];
            sum[i]     = {1'b0, base[i]} + {{CNT_W{1'b0}}, err_valid[i]};
            cnt_d[i]   = cnt_q[i];
            state_d[i] = state_q[i];
            if (enable) begin
                if (clr_src[i]) begin
                    cnt_d[i]   = '0;
                    state_d[i] = ST_OK;
                end else begin
                    cnt_d[i] = sum[i][CNT_W] ? CNT_MAX : sum[i][CNT_W-1:0];
                    // FSM looks at the registered count, so it trails the count by one edge
                    case (state_q[i])
                        ST_OK: begin
                            if (cnt_q[i] >= fail_thr_q)      state_d[i] = ST_FAIL;
                            else if (cnt_q[i] >= warn_thr_q) state_d[i] = ST_WARN;
                        end
                        ST_WARN: begin
                            if (cnt_q[i] >= fail_thr_q)      state_d[i] = ST_FAIL;
                            else if (cnt_q[i] < warn_lo)     state_d[i] = ST_OK;
                        end
                        ST_FAIL: begin
                            if (err_valid[i] && (err_sev[2*i +: 2] == 2'd3)) state_d[i] = ST_FATAL;
                            else if (cnt_q[i] < fail_lo)                      state_d[i] = ST_WARN;
                        end
                        default: state_d[i] = ST_FATAL;
                    endcase
                    esc[i] = (state_d[i] > state_q[i]);
                end
            end
        end
        int_status_d = enable ? ((int_status_q & ~int_clr) | esc) : int_status_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn_thr_q   <= CNT_W'(8);
            fail_thr_q   <= CNT_W'(16);
            hyst_q       <= CNT_W'(2);
            window_q     <= '0;
            timer_q      <= '0;
            win_tick_q   <= 1'b0;
            int_status_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= ST_OK;
            end
        end else begin
            if (enable && cfg_load) begin
                warn_thr_q <= cfg_warn_thr;
                fail_thr_q <= cfg_fail_thr;
                hyst_q     <= cfg_hyst;
                window_q   <= cfg_window;
            end
            timer_q      <= timer_d;
            win_tick_q   <= win_tick_d;
            int_status_q <= int_status_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        sys_warn  = 1'b0;
        sys_fail  = 1'b0;
        sys_fatal = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_state[2*i +: 2]         = state_q[i];
            src_count[CNT_W*i +: CNT_W] = cnt_q[i];
            sys_warn  = sys_warn  | (state_q[i] != ST_OK);
            sys_fail  = sys_fail  | (state_q[i] == ST_FAIL) | (state_q[i] == ST_FATAL);
            sys_fatal = sys_fatal | (state_q[i] == ST_FATAL);
        end
    end

    assign int_status = int_status_q;
    assign irq        = |(int_status_q & int_mask);
    assign win_tick   = win_tick_q;

endmodule

// File: tb/tb_error_rate_thresh_mon.sv
// tb/tb_error_rate_thresh_mon.sv - directed self-checking bench for error_rate_thresh_mon
module tb_error_rate_thresh_mon;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [7:0]   err_valid;
    logic [15:0]  err_sev;
    logic         cfg_load;
    logic [15:0]  cfg_warn_thr, cfg_fail_thr, cfg_hyst;
    logic [19:0]  cfg_window;
    logic [7:0]   clr_src, int_mask, int_clr;
    logic [15:0]  src_state;
    logic [127:0] src_count;
    logic [7:0]   int_status;
    logic         irq, sys_warn, sys_fail, sys_fatal, win_tick;

    logic         ev4, load4;
    logic [1:0]   sev4;
    logic [3:0]   thr4;
    logic [19:0]  win4;
    logic         zero4;
    logic [1:0]   state4;
    logic [3:0]   count4;
    logic         int4, irq4, warn4, fail4, fatal4, tick4;

    int total = 0;
    int bad   = 0;
    int n;

    error_rate_thresh_mon u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .err_valid(err_valid), .err_sev(err_sev),
        .cfg_load(cfg_load), .cfg_warn_thr(cfg_warn_thr), .cfg_fail_thr(cfg_fail_thr),
        .cfg_hyst(cfg_hyst), .cfg_window(cfg_window),
        .clr_src(clr_src), .int_mask(int_mask), .int_clr(int_clr),
        .src_state(src_state), .src_count(src_count), .int_status(int_status),
        .irq(irq), .sys_warn(sys_warn), .sys_fail(sys_fail), .sys_fatal(sys_fatal),
        .win_tick(win_tick)
    );

    error_rate_thresh_mon #(.NUM_SRC(1), .CNT_W(4), .WIN_W(20)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(1'b1),
        .err_valid(ev4), .err_sev(sev4),
        .cfg_load(load4), .cfg_warn_thr(thr4), .cfg_fail_thr(thr4),
        .cfg_hyst(thr4), .cfg_window(win4),
        .clr_src(zero4), .int_mask(zero4), .int_clr(zero4),
        .src_state(state4), .src_count(count4), .int_status(int4),
        .irq(irq4), .sys_warn(warn4), .sys_fail(fail4), .sys_fatal(fatal4),
        .win_tick(tick4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cnt(input int i);
        return src_count[16*i +: 16];
    endfunction

    function automatic logic [1:0] st(input int i);
        return src_state[2*i +: 2];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!win_tick && cycles < 100);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; err_valid = '0; err_sev = '0; cfg_load = 1'b0;
        cfg_warn_thr = '0; cfg_fail_thr = '0; cfg_hyst = '0; cfg_window = '0;
        clr_src = '0; int_mask = '0; int_clr = '0;
        ev4 = 1'b0; sev4 = '0; load4 = 1'b0; thr4 = '0; win4 = '0; zero4 = 1'b0;
        #12;
        chk("rst_count", 32'(|src_count), 32'd0);
        chk("rst_state", 32'(src_state), 32'd0);
        chk("rst_int", 32'(int_status), 32'd0);
        chk("rst_tick", 32'(win_tick), 32'd0);
        rst_n = 1'b1;
        step();

        // T1: warn escalation and masked irq
        cfg_load = 1'b1; cfg_warn_thr = 16'd4; cfg_fail_thr = 16'd8; cfg_hyst = 16'd2; cfg_window = '0;
        int_mask = 8'h01;
        step();
        cfg_load = 1'b0;
        err_valid = 8'h01; err_sev = 16'h0001;
        repeat (4) step();
        err_valid = '0;
        chk("t1_cnt4", 32'(cnt(0)), 32'd4);
        chk("t1_state_lag", 32'(st(0)), 32'd0);
        step();
        chk("t1_warn", 32'(st(0)), 32'd1);
        chk("t1_int", 32'(int_status), 32'h01);
        chk("t1_irq", 32'(irq), 32'd1);
        chk("t1_sys_warn", 32'(sys_warn), 32'd1);
        int_mask = 8'h00;
        #1;
        chk("t1_irq_masked", 32'(irq), 32'd0);
        int_mask = 8'h01;

        // T2: fail, fatal, clear
        err_valid = 8'h01;
        repeat (4) step();
        err_valid = '0;
        chk("t2_cnt8", 32'(cnt(0)), 32'd8);
        chk("t2_still_warn", 32'(st(0)), 32'd1);
        step();
        chk("t2_fail", 32'(st(0)), 32'd2);
        chk("t2_sys_fail", 32'(sys_fail), 32'd1);
        int_clr = 8'h01;
        step();
        int_clr = '0;
        chk("t2_w1c", 32'(int_status), 32'h00);
        err_valid = 8'h01; err_sev = 16'h0003;
        step();
        err_valid = '0; err_sev = '0;
        chk("t2_fatal", 32'(st(0)), 32'd3);
        chk("t2_cnt9", 32'(cnt(0)), 32'd9);
        chk("t2_int_fatal", 32'(int_status), 32'h01);
        chk("t2_sys_fatal", 32'(sys_fatal), 32'd1);
        step();
        chk("t2_sticky", 32'(st(0)), 32'd3);
        clr_src = 8'h01;
        step();
        clr_src = '0;
        chk("t2_clr_cnt", 32'(cnt(0)), 32'd0);
        chk("t2_clr_state", 32'(st(0)), 32'd0);
        chk("t2_clr_sys_fatal", 32'(sys_fatal), 32'd0);

        // T5: set beats clear; clr beats event
        int_clr = 8'h01;
        step();
        int_clr = '0;
        chk("t5_int_cleared", 32'(int_status), 32'h00);
        err_valid = 8'h01;
        repeat (4) step();
        err_valid = '0;
        int_clr = 8'h01;
        step();
        int_clr = '0;
        chk("t5_warn", 32'(st(0)), 32'd1);
        chk("t5_set_wins", 32'(int_status), 32'h01);
        err_valid = 8'h01; clr_src = 8'h01;
        step();
        err_valid = '0; clr_src = '0;
        chk("t5_clr_vs_event", 32'(cnt(0)), 32'd0);
        chk("t5_clr_state", 32'(st(0)), 32'd0);

        // T3: leaky window decay with hysteresis
        err_valid = 8'h01;
        repeat (8) step();
        err_valid = '0;
        step();
        chk("t3_fail", 32'(st(0)), 32'd2);
        int_clr = 8'h01; cfg_load = 1'b1; cfg_window = 20'd16;
        step();
        int_clr = '0; cfg_load = 1'b0;
        chk("t3_int_clr", 32'(int_status), 32'h00);
        wait_tick(n);
        chk("t3_tick1_period", 32'(n), 32'd16);
        chk("t3_tick1_cnt", 32'(cnt(0)), 32'd4);
        chk("t3_tick1_state", 32'(st(0)), 32'd2);
        step();
        chk("t3_to_warn", 32'(st(0)), 32'd1);
        chk("t3_tick_pulse", 32'(win_tick), 32'd0);
        wait_tick(n);
        chk("t3_tick2_period", 32'(n), 32'd15);
        chk("t3_tick2_cnt", 32'(cnt(0)), 32'd2);
        step();
        chk("t3_hyst_hold", 32'(st(0)), 32'd1);
        wait_tick(n);
        chk("t3_tick3_period", 32'(n), 32'd15);
        chk("t3_tick3_cnt", 32'(cnt(0)), 32'd1);
        step();
        chk("t3_to_ok", 32'(st(0)), 32'd0);
        chk("t3_no_int_on_deesc", 32'(int_status), 32'h00);

        // T6: freeze with enable=0
        cfg_load = 1'b1; cfg_window = 20'd10;
        step();
        cfg_load = 1'b0;
        err_valid = 8'h04;
        repeat (3) step();
        err_valid = '0;
        chk("t6_cnt2", 32'(cnt(2)), 32'd3);
        enable = 1'b0; err_valid = 8'hff; err_sev = 16'hffff; clr_src = 8'hff; int_clr = 8'hff;
        cfg_load = 1'b1; cfg_window = '0;
        repeat (50) step();
        chk("t6_frz_cnt0", 32'(cnt(0)), 32'd1);
        chk("t6_frz_cnt2", 32'(cnt(2)), 32'd3);
        chk("t6_frz_state", 32'(src_state), 32'd0);
        chk("t6_frz_tick", 32'(win_tick), 32'd0);
        chk("t6_frz_int", 32'(int_status), 32'h00);
        enable = 1'b1; err_valid = '0; err_sev = '0; clr_src = '0; int_clr = '0;
        cfg_load = 1'b0; cfg_window = 20'd10;
        wait_tick(n);
        chk("t6_timer_held", 32'(n), 32'd7);
        chk("t6_decay_cnt2", 32'(cnt(2)), 32'd1);
        chk("t6_decay_cnt0", 32'(cnt(0)), 32'd0);

        // T6: asynchronous reset mid-window
        err_valid = 8'h08;
        repeat (4) step();
        err_valid = '0;
        step();
        chk("t6_src3_warn", 32'(st(3)), 32'd1);
        chk("t6_src3_int", 32'(int_status), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_count", 32'(|src_count), 32'd0);
        chk("t6_arst_state", 32'(src_state), 32'd0);
        chk("t6_arst_int", 32'(int_status), 32'h00);
        chk("t6_arst_irq", 32'(irq), 32'd0);
        chk("t6_arst_sys", 32'({sys_warn, sys_fail, sys_fatal}), 32'd0);
        chk("t6_arst_tick", 32'(win_tick), 32'd0);
        #2;
        rst_n = 1'b1;

        // default thresholds after reset: warn 8, fail 16
        err_valid = 8'h01;
        repeat (8) step();
        err_valid = '0;
        chk("dflt_cnt8", 32'(cnt(0)), 32'd8);
        chk("dflt_lag", 32'(st(0)), 32'd0);
        step();
        chk("dflt_warn", 32'(st(0)), 32'd1);
        chk("dflt_no_tick", 32'(win_tick), 32'd0);

        // T4: saturation on a 4-bit counter
        ev4 = 1'b1;
        repeat (20) step();
        chk("t4_sat", 32'(count4), 32'd15);
        load4 = 1'b1; win4 = 20'd4;
        step();
        load4 = 1'b0;
        chk("t4_sat_hold", 32'(count4), 32'd15);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick4 && n < 100);
        chk("t4_tick_period", 32'(n), 32'd4);
        chk("t4_boundary_event", 32'(count4), 32'd8);
        ev4 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
